// File: rtl/prbs8_chk_if.sv
// Receive-side bundle between the PRBS8 checker and its consumer.
// master drives the serial input and clear; slave is the checker.
interface prbs8_chk_if;
    logic        en;
    logic        din;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    modport master (
        output en, din, clr_cnt,
        input  locked, err, err_count, bit_count
    );

    modport slave (
        input  en, din, clr_cnt,
        output locked, err, err_count, bit_count
    );
endinterface

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for PRBS8 (x^8+x^4+x^3+x^2+1).
// Define PRBS8_CHK_BITCNT_EN to build the 32-bit bit_count counter.
module prbs8_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    prbs8_chk_if.slave  bus
);

    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    state_t      state, state_n;
    logic [7:0]  h, h_n;
    logic [3:0]  fill_cnt, fill_cnt_n;
    logic [7:0]  match_cnt, match_cnt_n;
    logic [7:0]  win_cnt, win_cnt_n;
    logic [8:0]  win_err, win_err_n, win_err_inc;
    logic        err_q, err_n;
    logic [15:0] err_count;
    logic        inc_err, inc_bit;
    logic        p, miss;

    assign p    = h[1] ^ h[2] ^ h[3] ^ h[7];
    assign miss = bus.din ^ p;

    always_comb begin
        state_n     = state;
        h_n         = h;
        fill_cnt_n  = fill_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        win_err_inc = win_err + {8'd0, miss};
        err_n       = 1'b0;
        inc_err     = 1'b0;
        inc_bit     = 1'b0;
        if (bus.en) begin
            unique case (state)
                FILL: begin
                    h_n = {h[6:0], bus.din};
                    if (fill_cnt == 4'd7) begin
                        state_n     = SEARCH;
                        fill_cnt_n  = 4'd0;
                        match_cnt_n = 8'd0;
                    end else begin
                        fill_cnt_n = fill_cnt + 4'd1;
                    end
                end
                SEARCH: begin
                    h_n = {h[6:0], bus.din};
                    // all-zero history predicts zeros forever; never lock on it
                    if (!miss && h != 8'd0) begin
                        if (match_cnt == 8'(LOCK_CNT - 1)) begin
                            state_n     = LOCKED;
                            match_cnt_n = 8'd0;
                            win_cnt_n   = 8'd0;
                            win_err_n   = 9'd0;
                        end else begin
                            match_cnt_n = match_cnt + 8'd1;
                        end
                    end else begin
                        match_cnt_n = 8'd0;
                    end
                end
                LOCKED: begin
                    // free-run on the prediction so line errors don't propagate
                    h_n     = {h[6:0], p};
                    err_n   = miss;
                    inc_err = miss;
                    inc_bit = 1'b1;
                    if (win_err_inc >= 9'(UNLOCK_ERRS)) begin
                        state_n     = FILL;
                        fill_cnt_n  = 4'd0;
                        match_cnt_n = 8'd0;
                    end else if (win_cnt == 8'd254) begin
                        win_cnt_n = 8'd0;
                        win_err_n = 9'd0;
                    end else begin
                        win_cnt_n = win_cnt + 8'd1;
                        win_err_n = win_err_inc;
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= FILL;
            h         <= 8'd0;
            fill_cnt  <= 4'd0;
            match_cnt <= 8'd0;
            win_cnt   <= 8'd0;
            win_err   <= 9'd0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            h         <= h_n;
            fill_cnt  <= fill_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_q     <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.clr_cnt)
            err_count <= 16'd0;
        else if (inc_err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end

`ifdef PRBS8_CHK_BITCNT_EN
    logic [31:0] bit_count;

    always_ff @(posedge clk) begin
        if (!reset_n || bus.clr_cnt)
            bit_count <= 32'd0;
        else if (inc_bit && bit_count != 32'hFFFF_FFFF)
            bit_count <= bit_count + 32'd1;
    end

    assign bus.bit_count = bit_count;
`else
    logic unused_inc_bit;
    assign unused_inc_bit = inc_bit;
    assign bus.bit_count  = 32'd0;
`endif

    assign bus.locked    = (state == LOCKED);
    assign bus.err       = err_q;
    assign bus.err_count = err_count;

endmodule
